timestamp_replay: RTL and testbench

- Consumer side of the timestamp record stream. Pops 32-bit words from a first-word-fall-through FIFO.
- Reassembles 3-word, 64-bit timestamp records tagged with IDENTIFIER.
- Drives a pulse on DO when the local running timestamp reaches each record's target.
- Replays captured edge times onto a pin, e.g. for loopback verification of the capture path or trigger re-injection.

---
 rtl/timestamp_replay_pkg.sv | 33 +++
 rtl/timestamp_record_asm.sv | 81 ++++++++
 rtl/timestamp_replay.sv | 120 ++++++++++++
 tb/tb_timestamp_replay.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_replay_pkg.sv
// Shared types, constants and helpers for the timestamp replay block.
package timestamp_replay_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned TS_W      = 64;
  localparam int unsigned TAG_MSB   = 31;
  localparam int unsigned IDX_MSB   = 27;
  localparam int unsigned PAYLOAD_W = 24;
  localparam int unsigned HI_W      = 16;
  localparam int unsigned PCNT_W    = 8;

  localparam logic [3:0] IDX_HI  = 4'd1;
  localparam logic [3:0] IDX_MID = 4'd2;
  localparam logic [3:0] IDX_LO  = 4'd3;

  typedef logic [1:0] state_t;
  localparam state_t FETCH = 2'd0;
  localparam state_t ARMED = 2'd1;
  localparam state_t PULSE = 2'd2;

  // FIFO word: tag in [TAG_MSB:28], index in [IDX_MSB:24], payload below.
  typedef struct packed {
    logic [TAG_MSB-IDX_MSB-1:0] tag;
    logic [IDX_MSB-PAYLOAD_W:0] idx;
    logic [PAYLOAD_W-1:0]       payload;
  } word_t;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/timestamp_record_asm.sv
// Reassembles 3-word timestamp records; flags bad words and strobes on completion.
module timestamp_record_asm
  import timestamp_replay_pkg::*;
#(
  parameter logic [3:0] IDENTIFIER = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              pop,
  input  logic [WORD_W-1:0] data,
  output logic              err_c,
  output logic              done_c,
  output logic [TS_W-1:0]   target_c
);

  word_t                w;
  logic                 hi_ok;
  logic [HI_W-1:0]      hi, hi_n;
  logic [PAYLOAD_W-1:0] mid, mid_n;
  logic [3:0]           exp_idx, exp_n;

  assign w        = word_t'(data);
  assign hi_ok    = (w.payload[PAYLOAD_W-1:HI_W] == '0);
  assign target_c = {hi, mid, w.payload};

  // Index sequencing: a mismatching idx-1 word restarts a record instead of being lost.
  always_comb begin
    hi_n   = hi;
    mid_n  = mid;
    exp_n  = exp_idx;
    err_c  = 1'b0;
    done_c = 1'b0;
    if (clear) begin
      hi_n  = '0;
      mid_n = '0;
      exp_n = IDX_HI;
    end else if (pop) begin
      if (w.tag != IDENTIFIER) begin
        err_c = 1'b1;
      end else if ((w.idx == exp_idx) && !((w.idx == IDX_HI) && !hi_ok)) begin
        case (w.idx)
          IDX_HI: begin
            hi_n  = w.payload[HI_W-1:0];
            exp_n = IDX_MID;
          end
          IDX_MID: begin
            mid_n = w.payload;
            exp_n = IDX_LO;
          end
          default: begin
            done_c = 1'b1;
            exp_n  = IDX_HI;
          end
        endcase
      end else begin
        err_c = 1'b1;
        hi_n  = '0;
        mid_n = '0;
        exp_n = IDX_HI;
        if ((w.idx == IDX_HI) && hi_ok) begin
          hi_n  = w.payload[HI_W-1:0];
          exp_n = IDX_MID;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      mid     <= '0;
      exp_idx <= IDX_HI;
    end else begin
      hi      <= hi_n;
      mid     <= mid_n;
      exp_idx <= exp_n;
    end
  end

endmodule

// File: rtl/timestamp_replay.sv
// Pops timestamp records from a FWFT FIFO and replays each as a pulse on DO
// once the local running time reaches the record's target.
module timestamp_replay
  import timestamp_replay_pkg::*;
#(
  parameter logic [3:0]  IDENTIFIER = 4'b0001,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ENABLE,
  input  logic [TS_W-1:0]      TIMESTAMP_IN,
  input  logic                 FIFO_EMPTY,
  input  logic [WORD_W-1:0]    FIFO_DATA,
  output logic                 FIFO_READ,
  output logic                 DO,
  output logic                 BUSY,
  output logic [TS_W-1:0]      TARGET_OUT,
  output logic [CNT_WIDTH-1:0] REC_CNT,
  output logic [CNT_WIDTH-1:0] LATE_CNT,
  output logic [CNT_WIDTH-1:0] ERR_CNT
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  state_t                state, state_n;
  logic [PCNT_W-1:0]     pcnt, pcnt_n;
  logic                  first, first_n;
  logic                  do_n, busy_n;
  logic [TS_W-1:0]       target_n;
  logic [CNT_WIDTH-1:0]  rec_n, late_n, err_n;
  logic                  err_c, done_c;
  logic [TS_W-1:0]       target_c;

  assign FIFO_READ = (state == FETCH) && ENABLE && !FIFO_EMPTY;

  timestamp_record_asm #(.IDENTIFIER(IDENTIFIER)) u_asm (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (!ENABLE),
    .pop      (FIFO_READ),
    .data     (FIFO_DATA),
    .err_c    (err_c),
    .done_c   (done_c),
    .target_c (target_c)
  );

  // Next state, pulse timing and status counters.
  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    first_n  = 1'b0;
    do_n     = DO;
    target_n = TARGET_OUT;
    rec_n    = REC_CNT;
    late_n   = LATE_CNT;
    err_n    = ERR_CNT;
    if (err_c) err_n = CNT_WIDTH'(sat_inc(32'(ERR_CNT), CNT_MAX));
    case (state)
      FETCH: begin
        if (done_c) begin
          target_n = target_c;
          first_n  = 1'b1;
          state_n  = ARMED;
        end
      end
      ARMED: begin
        if (!ENABLE) begin
          state_n = FETCH;
        end else if (TIMESTAMP_IN >= TARGET_OUT) begin
          do_n    = 1'b1;
          pcnt_n  = PCNT_W'(PULSE_LEN - 1);
          rec_n   = CNT_WIDTH'(sat_inc(32'(REC_CNT), CNT_MAX));
          if (first && (TIMESTAMP_IN > TARGET_OUT))
            late_n = CNT_WIDTH'(sat_inc(32'(LATE_CNT), CNT_MAX));
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (pcnt == '0) begin
          do_n    = 1'b0;
          state_n = FETCH;
        end else begin
          pcnt_n = pcnt - PCNT_W'(1);
        end
      end
      default: begin
        do_n    = 1'b0;
        state_n = FETCH;
      end
    endcase
    busy_n = (state_n == ARMED) || (state_n == PULSE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= FETCH;
      pcnt       <= '0;
      first      <= 1'b0;
      DO         <= 1'b0;
      BUSY       <= 1'b0;
      TARGET_OUT <= '0;
      REC_CNT    <= '0;
      LATE_CNT   <= '0;
      ERR_CNT    <= '0;
    end else begin
      state      <= state_n;
      pcnt       <= pcnt_n;
      first      <= first_n;
      DO         <= do_n;
      BUSY       <= busy_n;
      TARGET_OUT <= target_n;
      REC_CNT    <= rec_n;
      LATE_CNT   <= late_n;
      ERR_CNT    <= err_n;
    end
  end

endmodule

// File: tb/tb_timestamp_replay.sv
// Directed, self-checking bench for timestamp_replay with a small FWFT FIFO model.
module tb_timestamp_replay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [63:0] timestamp_in;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;
  logic        do_out;
  logic        busy;
  logic [63:0] target_out;
  logic [15:0] rec_cnt, late_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timestamp_replay #(.IDENTIFIER(4'b0001), .PULSE_LEN(4), .CNT_WIDTH(16)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .ENABLE       (enable),
    .TIMESTAMP_IN (timestamp_in),
    .FIFO_EMPTY   (fifo_empty),
    .FIFO_DATA    (fifo_data),
    .FIFO_READ    (fifo_read),
    .DO           (do_out),
    .BUSY         (busy),
    .TARGET_OUT   (target_out),
    .REC_CNT      (rec_cnt),
    .LATE_CNT     (late_cnt),
    .ERR_CNT      (err_cnt)
  );

  // FWFT FIFO model: bench pushes, DUT pops.
  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];
  always @(posedge clk) if (fifo_read) rd_ptr <= rd_ptr + 8'd1;

  // Local time: static at ts_base, or counting from ts_base when ts_run is set.
  logic [63:0] cyc = 64'd0;
  logic [63:0] ts_base = 64'd0;
  logic [63:0] ts_start = 64'd0;
  logic        ts_run = 1'b0;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign timestamp_in = ts_run ? ts_base + (cyc - ts_start) : ts_base;

  typedef struct {
    logic [31:0] w0, w1, w2;
    logic [63:0] ts;
    logic [63:0] exp_target;
    logic [63:0] exp_late;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_do(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (do_out === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_width(output int wid);
    wid = 0;
    while (do_out === 1'b1 && wid < 300) begin
      wid++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wid, rises, viol, fr_fall, seen_fall, highs;
    logic prev_do;
    logic [63:0] prev_ts;
    logic [15:0] r0, l0, e0;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    vecs[0] = '{32'h1100_0000, 32'h1200_0001, 32'h1300_0010, 64'h2_0000_0000,
                64'h0000_0000_0100_0010, 64'd1};
    vecs[1] = '{32'h1100_ABCD, 32'h1212_3456, 32'h1378_9ABC, 64'hABCD_1234_5678_9ABC,
                64'hABCD_1234_5678_9ABC, 64'd0};
    vecs[2] = '{32'h1100_FFFF, 32'h12FF_FFFF, 32'h13FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[3] = '{32'h1100_0000, 32'h1200_0000, 32'h1300_0000, 64'd1, 64'd0, 64'd1};

    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_do", 64'(do_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_read", 64'(fifo_read), 64'd0);
    check("rst_target", target_out, 64'd0);
    check("rst_rec", 64'(rec_cnt), 64'd0);
    check("rst_late", 64'(late_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;

    // Table: single records against a held timestamp.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ts_run = 1'b0;
      ts_base = vecs[i].ts;
      r0 = rec_cnt; l0 = late_cnt; e0 = err_cnt;
      push(vecs[i].w0); push(vecs[i].w1); push(vecs[i].w2);
      wait_do(40, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      pulse_width(wid);
      check($sformatf("vec%0d_width", i), 64'(wid), 64'd4);
      check($sformatf("vec%0d_target", i), target_out, vecs[i].exp_target);
      check($sformatf("vec%0d_rec", i), 64'(rec_cnt - r0), 64'd1);
      check($sformatf("vec%0d_late", i), 64'(late_cnt - l0), vecs[i].exp_late);
      check($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'd0);
    end

    // Running time: fire one cycle after time reaches the target.
    @(negedge clk);
    ts_base = 64'h1_0000_0000; ts_start = cyc; ts_run = 1'b1;
    r0 = rec_cnt; l0 = late_cnt;
    push(32'h1100_0000); push(32'h1200_0100); push(32'h1300_0010);
    lat = 0; prev_ts = timestamp_in;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (do_out === 1'b1) begin lat = 1; break; end
      prev_ts = timestamp_in;
    end
    check("run_fired", 64'(lat), 64'd1);
    check("run_ts_before_rise", prev_ts, 64'h1_0000_0010);
    pulse_width(wid);
    check("run_width", 64'(wid), 64'd4);
    check("run_target", target_out, 64'h1_0000_0010);
    check("run_rec", 64'(rec_cnt - r0), 64'd1);
    check("run_late", 64'(late_cnt - l0), 64'd0);
    ts_run = 1'b0;

    // Bad tag and skipped index in the stream.
    @(negedge clk);
    ts_base = 64'h100;
    r0 = rec_cnt; l0 = late_cnt; e0 = err_cnt;
    push(32'h2100_0000); push(32'h1100_0000); push(32'h1300_0005);
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0007);
    wait_do(40, lat);
    check("err_latency", 64'(lat), 64'd7);
    pulse_width(wid);
    highs = 0;
    repeat (10) begin @(negedge clk); if (do_out === 1'b1) highs++; end
    check("err_extra_pulses", 64'(highs), 64'd0);
    check("err_errcnt", 64'(err_cnt - e0), 64'd2);
    check("err_rec", 64'(rec_cnt - r0), 64'd1);
    check("err_late", 64'(late_cnt - l0), 64'd1);
    check("err_target", target_out, 64'h7);
    e0 = err_cnt;
    push(32'h1101_0000);
    repeat (3) @(negedge clk);
    check("hi_reserved_err", 64'(err_cnt - e0), 64'd1);
    check("hi_reserved_busy", 64'(busy), 64'd0);

    // Two records back to back: no pops while busy, separate pulses.
    @(negedge clk);
    ts_base = 64'h10;
    l0 = late_cnt;
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0001);
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0002);
    rises = 0; viol = 0; fr_fall = 0; seen_fall = 0; prev_do = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (do_out && !prev_do) rises++;
      if (busy && fifo_read) viol++;
      if (prev_do && !do_out && seen_fall == 0) begin
        seen_fall = 1;
        fr_fall = int'(fifo_read);
      end
      prev_do = do_out;
    end
    check("b2b_rises", 64'(rises), 64'd2);
    check("b2b_read_while_busy", 64'(viol), 64'd0);
    check("b2b_read_after_fall", 64'(fr_fall), 64'd1);
    check("b2b_target", target_out, 64'h2);
    check("b2b_late", 64'(late_cnt - l0), 64'd2);

    // ENABLE dropped while armed discards the record.
    @(negedge clk);
    ts_base = 64'd0;
    r0 = rec_cnt;
    push(32'h1100_0001); push(32'h1200_0000); push(32'h1300_0000);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin lat = k; break; end
    end
    check("dis_armed", 64'(lat), 64'd3);
    check("dis_target", target_out, 64'h0001_0000_0000_0000);
    enable = 1'b0;
    @(negedge clk);
    check("dis_busy", 64'(busy), 64'd0);
    highs = 0;
    repeat (5) begin @(negedge clk); if (do_out === 1'b1) highs++; end
    check("dis_no_pulse", 64'(highs), 64'd0);
    check("dis_rec", 64'(rec_cnt - r0), 64'd0);
    enable = 1'b1;
    ts_base = 64'h40;
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0030);
    wait_do(40, lat);
    check("reen_latency", 64'(lat), 64'd4);
    pulse_width(wid);
    check("reen_target", target_out, 64'h30);
    check("reen_rec", 64'(rec_cnt - r0), 64'd1);

    // Asynchronous reset in the middle of a pulse.
    @(negedge clk);
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0003);
    wait_do(40, lat);
    check("rstp_fired", 64'(lat), 64'd4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstp_do", 64'(do_out), 64'd0);
    check("rstp_busy", 64'(busy), 64'd0);
    check("rstp_rec", 64'(rec_cnt), 64'd0);
    check("rstp_late", 64'(late_cnt), 64'd0);
    check("rstp_err", 64'(err_cnt), 64'd0);
    check("rstp_target", target_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h1100_0000); push(32'h1200_0000); push(32'h1300_0003);
    #1;
    check("rstp_read_resumes", 64'(fifo_read), 64'd1);
    wait_do(40, lat);
    check("rstp_refire", 64'(lat), 64'd4);
    pulse_width(wid);
    check("rstp_rec_after", 64'(rec_cnt), 64'd1);
    check("rstp_late_after", 64'(late_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
